// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the upstream request port, the data-memory
// request/grant/response port and the writeback/fault outputs of the
// load/store unit.
//   slave  : the load/store unit itself.
//   master : the surroundings (EX/MEM stage plus data memory), which drive
//            requests and the memory grant/response.
interface load_store_unit_if #(
   parameter int XLEN = 32
);
   // upstream request
   logic            req_valid;
   logic            req_ready;
   logic            mem_read;
   logic            mem_write;
   logic [2:0]      funct3;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [4:0]      rd_in;
   // data memory port
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;
   // writeback / status
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            store_done;
   logic            fault;
   logic [XLEN-1:0] fault_addr;

   modport slave (
      input  req_valid, mem_read, mem_write, funct3, addr, wdata, rd_in,
      input  dmem_gnt, dmem_rvalid, dmem_rdata,
      output req_ready,
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output wb_valid, wb_rd, wb_data, store_done, fault, fault_addr
   );

   modport master (
      output req_valid, mem_read, mem_write, funct3, addr, wdata, rd_in,
      output dmem_gnt, dmem_rvalid, dmem_rdata,
      input  req_ready,
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  wb_valid, wb_rd, wb_data, store_done, fault, fault_addr
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-stage load/store unit.
// Takes the ALU result as effective address, rs2 as store data and funct3 as
// access size/signedness. Legal accesses go out on a request/grant/response
// data-memory port with byte enables and lane-replicated store data; loads
// come back sign/zero-extended on wb_*. Misaligned or illegal accesses never
// reach memory and pulse fault for one cycle instead.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : load_store_unit_if.slave (request, dmem port, writeback,
//                store_done, fault/fault_addr). All outputs are registered
//                except req_ready, which is decoded from the state.
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t          state_reg, state_next;
   logic            dmem_req_reg,   dmem_req_next;
   logic            dmem_we_reg,    dmem_we_next;
   logic [XLEN-1:0] dmem_addr_reg,  dmem_addr_next;
   logic [3:0]      dmem_be_reg,    dmem_be_next;
   logic [XLEN-1:0] dmem_wdata_reg, dmem_wdata_next;
   logic            wb_valid_reg,   wb_valid_next;
   logic [4:0]      wb_rd_reg,      wb_rd_next;
   logic [XLEN-1:0] wb_data_reg,    wb_data_next;
   logic            store_done_reg, store_done_next;
   logic            fault_reg,      fault_next;
   logic [XLEN-1:0] fault_addr_reg, fault_addr_next;
   // captured op context needed once the response arrives
   logic [2:0]      op_funct3_reg,  op_funct3_next;
   logic [1:0]      op_off_reg,     op_off_next;
   logic [4:0]      op_rd_reg,      op_rd_next;

   logic [1:0]      off;
   logic [1:0]      size;
   logic            accept;
   logic            illegal;
   logic [3:0]      req_be;
   logic [XLEN-1:0] store_wdata;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] load_data;

   assign off    = bus.addr[1:0];
   assign size   = bus.funct3[1:0];
   // ops with neither read nor write are simply not accepted
   assign accept = bus.req_valid && (state_reg == S_IDLE) && (bus.mem_read || bus.mem_write);

   always_comb begin
      illegal = 1'b0;
      if (bus.mem_read && bus.mem_write)
         illegal = 1'b1;
      else if (bus.mem_read)
         illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
      else
         illegal = bus.funct3[2] || (size == 2'b11);
      if ((size == 2'b01) && off[0])
         illegal = 1'b1;
      if ((size == 2'b10) && (off != 2'b00))
         illegal = 1'b1;
   end

   always_comb begin
      case (size)
         2'b00:   req_be = 4'b0001 << off;
         2'b01:   req_be = off[1] ? 4'b1100 : 4'b0011;
         default: req_be = 4'b1111;
      endcase
   end

   // Replicate store data across lanes so memory can pick any lane by be.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign store_wdata[8*gi +: 8] = (size == 2'b00) ? bus.wdata[7:0] :
                                      (size == 2'b01) ? bus.wdata[8*(gi%2) +: 8] :
                                                        bus.wdata[8*gi +: 8];
   end

   always_comb begin
      case (op_off_reg)
         2'd0:    ld_byte = bus.dmem_rdata[7:0];
         2'd1:    ld_byte = bus.dmem_rdata[15:8];
         2'd2:    ld_byte = bus.dmem_rdata[23:16];
         default: ld_byte = bus.dmem_rdata[31:24];
      endcase
      ld_half = op_off_reg[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
      case (op_funct3_reg)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_data = {24'd0, ld_byte};
         3'b101:  load_data = {16'd0, ld_half};
         default: load_data = bus.dmem_rdata;
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      dmem_req_next   = dmem_req_reg;
      dmem_we_next    = dmem_we_reg;
      dmem_addr_next  = dmem_addr_reg;
      dmem_be_next    = dmem_be_reg;
      dmem_wdata_next = dmem_wdata_reg;
      wb_valid_next   = 1'b0;
      wb_rd_next      = wb_rd_reg;
      wb_data_next    = wb_data_reg;
      store_done_next = 1'b0;
      fault_next      = 1'b0;
      fault_addr_next = fault_addr_reg;
      op_funct3_next  = op_funct3_reg;
      op_off_next     = op_off_reg;
      op_rd_next      = op_rd_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               if (illegal) begin
                  fault_next      = 1'b1;
                  fault_addr_next = bus.addr;
               end else begin
                  state_next      = S_REQ;
                  dmem_req_next   = 1'b1;
                  dmem_we_next    = bus.mem_write;
                  dmem_addr_next  = {bus.addr[XLEN-1:2], 2'b00};
                  dmem_be_next    = req_be;
                  dmem_wdata_next = store_wdata;
                  op_funct3_next  = bus.funct3;
                  op_off_next     = off;
                  op_rd_next      = bus.rd_in;
               end
            end
         end
         S_REQ: begin
            // dmem_* registers are untouched here, so they stay stable until gnt
            if (bus.dmem_gnt) begin
               dmem_req_next = 1'b0;
               if (dmem_we_reg) begin
                  store_done_next = 1'b1;
                  state_next      = S_IDLE;
               end else begin
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.dmem_rvalid) begin
               wb_valid_next = 1'b1;
               wb_rd_next    = op_rd_reg;
               wb_data_next  = load_data;
               state_next    = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req_reg   <= 1'b0;
         dmem_we_reg    <= 1'b0;
         dmem_addr_reg  <= '0;
         dmem_be_reg    <= '0;
         dmem_wdata_reg <= '0;
         wb_valid_reg   <= 1'b0;
         wb_rd_reg      <= '0;
         wb_data_reg    <= '0;
         store_done_reg <= 1'b0;
         fault_reg      <= 1'b0;
         fault_addr_reg <= '0;
         op_funct3_reg  <= '0;
         op_off_reg     <= '0;
         op_rd_reg      <= '0;
      end else begin
         dmem_req_reg   <= dmem_req_next;
         dmem_we_reg    <= dmem_we_next;
         dmem_addr_reg  <= dmem_addr_next;
         dmem_be_reg    <= dmem_be_next;
         dmem_wdata_reg <= dmem_wdata_next;
         wb_valid_reg   <= wb_valid_next;
         wb_rd_reg      <= wb_rd_next;
         wb_data_reg    <= wb_data_next;
         store_done_reg <= store_done_next;
         fault_reg      <= fault_next;
         fault_addr_reg <= fault_addr_next;
         op_funct3_reg  <= op_funct3_next;
         op_off_reg     <= op_off_next;
         op_rd_reg      <= op_rd_next;
      end
   end

   assign bus.req_ready  = (state_reg == S_IDLE);
   assign bus.dmem_req   = dmem_req_reg;
   assign bus.dmem_we    = dmem_we_reg;
   assign bus.dmem_addr  = dmem_addr_reg;
   assign bus.dmem_be    = dmem_be_reg;
   assign bus.dmem_wdata = dmem_wdata_reg;
   assign bus.wb_valid   = wb_valid_reg;
   assign bus.wb_rd      = wb_rd_reg;
   assign bus.wb_data    = wb_data_reg;
   assign bus.store_done = store_done_reg;
   assign bus.fault      = fault_reg;
   assign bus.fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a behavioural model built from the access rules (sizes in bytes,
// byte shifts, arithmetic sign extension).
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [31:0] last_fault_addr = 32'd0;

   always #5 clk = ~clk;

   load_store_unit_if bus ();

   load_store_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int size_bytes(input logic [2:0] f3);
      return 1 << (f3 % 4);
   endfunction

   function automatic bit model_fault(input bit r, input bit w, input logic [2:0] f3,
                                      input logic [31:0] a);
      if (r && w) return 1'b1;
      if (r && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      if (w && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
      return (a % size_bytes(f3)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int n = size_bytes(f3);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int n = size_bytes(f3);
      logic [31:0] res = 32'd0;
      for (int i = 0; i < 4; i++)
         res = res | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
      return res;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rdata);
      int n = size_bytes(f3);
      longint v;
      longint full;
      if (n == 4) return rdata;
      full = longint'(1) << (8 * n);
      v = longint'(rdata >> (8 * (a % 4))) & (full - 1);
      if (f3 < 4 && v >= full / 2) v = v - full;
      return 32'(v);
   endfunction

   task automatic idle_inputs;
      bus.req_valid   = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.funct3      = 3'd0;
      bus.addr        = 32'd0;
      bus.wdata       = 32'd0;
      bus.rd_in       = 5'd0;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 32'd0;
   endtask

   // One complete operation: accept, gd grant wait cycles, rvd response wait
   // cycles, with every observable cycle checked against the model.
   task automatic do_op(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int gd,
                        input int rvd, input logic [31:0] rdata, input string tag);
      bit          flt = model_fault(r, w, f3, a);
      logic [31:0] eaddr = a & 32'hFFFF_FFFC;
      logic [3:0]  ebe = model_be(f3, a);
      logic [31:0] ewd = model_wdata(f3, wd);
      logic [31:0] eld = model_load(f3, a, rdata);
      bus.req_valid = 1'b1; bus.mem_read = r; bus.mem_write = w;
      bus.funct3 = f3; bus.addr = a; bus.wdata = wd; bus.rd_in = rd;
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL %s ready_c0 got=%b exp=1", tag, bus.req_ready); end
      step;
      bus.req_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      if (flt) begin
         last_fault_addr = a;
         total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL %s fault got=%b exp=1", tag, bus.fault); end
         total++; if (bus.fault_addr !== a) begin bad++; $display("FAIL %s fault_addr got=%h exp=%h", tag, bus.fault_addr, a); end
         total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL %s fault_req got=%b exp=0", tag, bus.dmem_req); end
         total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL %s fault_ready got=%b exp=1", tag, bus.req_ready); end
         step;
         total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL %s fault_pulse got=%b exp=0", tag, bus.fault); end
      end else begin
         for (int i = 0; i <= gd; i++) begin
            bus.dmem_gnt = (i == gd);
            total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL %s req[%0d] got=%b exp=1", tag, i, bus.dmem_req); end
            total++; if (bus.dmem_we !== w) begin bad++; $display("FAIL %s we got=%b exp=%b", tag, bus.dmem_we, w); end
            total++; if (bus.dmem_addr !== eaddr) begin bad++; $display("FAIL %s daddr got=%h exp=%h", tag, bus.dmem_addr, eaddr); end
            total++; if (bus.dmem_be !== ebe) begin bad++; $display("FAIL %s be got=%b exp=%b", tag, bus.dmem_be, ebe); end
            if (w) begin
               total++; if (bus.dmem_wdata !== ewd) begin bad++; $display("FAIL %s dwdata got=%h exp=%h", tag, bus.dmem_wdata, ewd); end
            end
            total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL %s busy_ready got=%b exp=0", tag, bus.req_ready); end
            total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL %s spurious_fault got=%b exp=0", tag, bus.fault); end
            step;
         end
         bus.dmem_gnt = 1'b0;
         if (w) begin
            total++; if (bus.store_done !== 1'b1) begin bad++; $display("FAIL %s store_done got=%b exp=1", tag, bus.store_done); end
            total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL %s req_drop got=%b exp=0", tag, bus.dmem_req); end
            total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL %s st_ready got=%b exp=1", tag, bus.req_ready); end
            step;
            total++; if (bus.store_done !== 1'b0) begin bad++; $display("FAIL %s store_pulse got=%b exp=0", tag, bus.store_done); end
         end else begin
            for (int i = 0; i <= rvd; i++) begin
               bus.dmem_rvalid = (i == rvd);
               bus.dmem_rdata  = (i == rvd) ? rdata : $urandom;
               total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL %s early_wb got=%b exp=0", tag, bus.wb_valid); end
               total++; if (bus.dmem_req !== 1'b0 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL %s wait_state req=%b ready=%b exp=0,0", tag, bus.dmem_req, bus.req_ready); end
               step;
            end
            bus.dmem_rvalid = 1'b0;
            total++; if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL %s wb_valid got=%b exp=1", tag, bus.wb_valid); end
            total++; if (bus.wb_data !== eld) begin bad++; $display("FAIL %s wb_data got=%h exp=%h", tag, bus.wb_data, eld); end
            total++; if (bus.wb_rd !== rd) begin bad++; $display("FAIL %s wb_rd got=%0d exp=%0d", tag, bus.wb_rd, rd); end
            total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL %s ld_ready got=%b exp=1", tag, bus.req_ready); end
            step;
            total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL %s wb_pulse got=%b exp=0", tag, bus.wb_valid); end
         end
      end
      total++; if (bus.fault_addr !== last_fault_addr) begin bad++; $display("FAIL %s fault_addr_hold got=%h exp=%h", tag, bus.fault_addr, last_fault_addr); end
      $display("op %s r=%0b w=%0b f3=%0d addr=%h fault=%0b", tag, r, w, f3, a, flt);
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_n = 1'b0;
      step;
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
      total++; if ({bus.dmem_req, bus.dmem_we, bus.wb_valid, bus.store_done, bus.fault} !== 5'd0) begin bad++; $display("FAIL reset_pulses got=%b exp=00000", {bus.dmem_req, bus.dmem_we, bus.wb_valid, bus.store_done, bus.fault}); end
      total++; if ({bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.wb_rd, bus.wb_data, bus.fault_addr} !== 169'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.wb_rd, bus.wb_data, bus.fault_addr}); end
      rst_n = 1'b1;
      step;
      total++; if (bus.req_ready !== 1'b1 || bus.dmem_req !== 1'b0) begin bad++; $display("FAIL post_reset ready=%b req=%b exp=1,0", bus.req_ready, bus.dmem_req); end
      $display("reset checked");
   endtask

   task automatic test_ignored;
      // no read/write, stray gnt/rvalid while idle: nothing happens
      bus.req_valid = 1'b1; bus.addr = 32'h44; bus.funct3 = 3'd2;
      bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b1;
      step;
      idle_inputs();
      step;
      total++; if ({bus.dmem_req, bus.fault, bus.wb_valid, bus.store_done} !== 4'd0) begin bad++; $display("FAIL ignored_op got=%b exp=0000", {bus.dmem_req, bus.fault, bus.wb_valid, bus.store_done}); end
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL ignored_ready got=%b exp=1", bus.req_ready); end
      $display("ignored request checked");
   endtask

   task automatic test_directed;
      do_op(1, 0, 3'b000, 32'h103, 32'd0, 5'd5, 0, 0, 32'h80FF_FFFF, "LB_103");
      do_op(1, 0, 3'b100, 32'h103, 32'd0, 5'd6, 0, 0, 32'h80FF_FFFF, "LBU_103");
      do_op(0, 1, 3'b001, 32'h22, 32'h1234_ABCD, 5'd0, 0, 0, 32'd0, "SH_22");
      do_op(1, 0, 3'b010, 32'h40, 32'd0, 5'd9, 3, 1, 32'hDEAD_BEEF, "LW_40_stall");
      do_op(1, 0, 3'b001, 32'h202, 32'd0, 5'd0, 1, 0, 32'h8001_7FFF, "LH_x0");
      do_op(1, 0, 3'b101, 32'h202, 32'd0, 5'd1, 0, 2, 32'h8001_7FFF, "LHU_202");
      do_op(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 5'd0, 2, 0, 32'd0, "SB_301");
   endtask

   task automatic test_faults;
      do_op(1, 0, 3'b010, 32'h41, 32'd0, 5'd1, 0, 0, 32'd0, "LW_41");
      do_op(0, 1, 3'b001, 32'h23, 32'h55, 5'd0, 0, 0, 32'd0, "SH_23");
      do_op(1, 0, 3'b011, 32'h80, 32'd0, 5'd2, 0, 0, 32'd0, "LD_f3_011");
      do_op(1, 1, 3'b010, 32'h90, 32'd0, 5'd2, 0, 0, 32'd0, "RW_both");
      do_op(0, 1, 3'b100, 32'hA0, 32'd0, 5'd0, 0, 0, 32'd0, "ST_f3_100");
      // a legal op afterwards leaves fault_addr at the last offender
      do_op(0, 1, 3'b010, 32'hB0, 32'h0BAD_F00D, 5'd0, 0, 0, 32'd0, "SW_after_fault");
   endtask

   task automatic test_reset_mid;
      // reset during REQ: dmem_req drops without a clock edge
      bus.req_valid = 1'b1; bus.mem_read = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h80; bus.rd_in = 5'd4;
      step;
      idle_inputs();
      total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL rst_req_pre got=%b exp=1", bus.dmem_req); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.dmem_req !== 1'b0 || bus.dmem_addr !== 32'd0) begin bad++; $display("FAIL rst_req_async req=%b addr=%h exp=0,0", bus.dmem_req, bus.dmem_addr); end
      step;
      rst_n = 1'b1;
      step;
      // reset during WAIT
      bus.req_valid = 1'b1; bus.mem_read = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h84; bus.rd_in = 5'd7;
      step;
      idle_inputs();
      bus.dmem_gnt = 1'b1;
      step;
      bus.dmem_gnt = 1'b0;
      total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_wait_pre ready=%b exp=0", bus.req_ready); end
      #3 rst_n = 1'b0;
      #1;
      last_fault_addr = 32'd0;
      total++; if ({bus.dmem_req, bus.dmem_we, bus.wb_valid, bus.store_done, bus.fault} !== 5'd0) begin bad++; $display("FAIL rst_wait_pulses got=%b exp=00000", {bus.dmem_req, bus.dmem_we, bus.wb_valid, bus.store_done, bus.fault}); end
      total++; if ({bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.wb_rd, bus.wb_data, bus.fault_addr} !== 169'd0) begin bad++; $display("FAIL rst_wait_regs got=%h exp=0", {bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.wb_rd, bus.wb_data, bus.fault_addr}); end
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_wait_ready got=%b exp=1", bus.req_ready); end
      step;
      rst_n = 1'b1;
      step;
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1234_5678;
      step;
      bus.dmem_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL stray_rvalid[%0d] got=%b exp=0", i, bus.wb_valid); end
         step;
      end
      $display("reset mid-operation checked");
   endtask

   task automatic test_back_to_back;
      int sd_count = 0;
      bus.req_valid = 1'b1; bus.mem_write = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h10; bus.wdata = 32'h0102_0304;
      step;
      idle_inputs();
      total++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin bad++; $display("FAIL b2b_sw_req req=%b we=%b exp=1,1", bus.dmem_req, bus.dmem_we); end
      bus.dmem_gnt = 1'b1;
      step;
      bus.dmem_gnt = 1'b0;
      sd_count += int'(bus.store_done);
      total++; if (bus.store_done !== 1'b1 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL b2b_sd done=%b ready=%b exp=1,1", bus.store_done, bus.req_ready); end
      bus.req_valid = 1'b1; bus.mem_read = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h10; bus.rd_in = 5'd3;
      step;
      idle_inputs();
      sd_count += int'(bus.store_done);
      total++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h10) begin bad++; $display("FAIL b2b_lw_req req=%b we=%b addr=%h exp=1,0,10", bus.dmem_req, bus.dmem_we, bus.dmem_addr); end
      bus.dmem_gnt = 1'b1;
      step;
      bus.dmem_gnt = 1'b0;
      sd_count += int'(bus.store_done);
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFE_BABE;
      step;
      bus.dmem_rvalid = 1'b0;
      total++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hCAFE_BABE || bus.wb_rd !== 5'd3) begin bad++; $display("FAIL b2b_wb v=%b data=%h rd=%0d exp=1,cafebabe,3", bus.wb_valid, bus.wb_data, bus.wb_rd); end
      step;
      sd_count += int'(bus.store_done);
      total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_wb_pulse got=%b exp=0", bus.wb_valid); end
      total++; if (sd_count != 1) begin bad++; $display("FAIL b2b_store_done_count got=%0d exp=1", sd_count); end
      $display("back-to-back store/load checked");
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         int kind = int'($urandom_range(0, 7));
         bit r = (kind <= 3) || (kind == 7);
         bit w = (kind >= 4);
         logic [2:0] f3 = 3'($urandom_range(0, 7));
         logic [31:0] a = $urandom;
         do_op(r, w, f3, a, $urandom, 5'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)), $urandom, $sformatf("rnd%0d", n));
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ignored();
      test_directed();
      test_faults();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV32I core, directly downstream of the EX-stage ALU. It takes the ALU result as the effective address, plus rs2 data, funct3 and the MemRead/MemWrite controls. It drives a request/grant/response data-memory port with byte enables and returns sign- or zero-extended load data to writeback. Misaligned and illegal accesses never reach memory and raise a one-cycle fault instead.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX/MEM presents a memory operation.
- req_ready  out  1  unit idle; high when state is IDLE. Upstream stalls while low.
- mem_read  in  1  load (ControlUnit MemRead).
- mem_write  in  1  store (ControlUnit MemWrite).
- funct3  in  3  access size and signedness.
- addr  in  32  effective address (ALU Result).
- wdata  in  32  store data (rs2).
- rd_in  in  5  load destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- wb_valid  out  1  one-cycle pulse: load result ready.
- wb_rd  out  5  destination register.
- wb_data  out  32  extended load data.
- store_done  out  1  one-cycle pulse: store granted.
- fault  out  1  one-cycle pulse: misaligned or illegal access.
- fault_addr  out  32  offending address; held until the next fault.

## Operation
- **Acceptance**
  - Accept when req_valid && req_ready.
  - Capture mem_read, mem_write, funct3, addr, wdata and rd_in.
  - req_valid with mem_read = mem_write = 0 is ignored; no state change.
- **Legality**
  - Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Legal stores: SB 000, SH 001, SW 010.
  - Fault on: any other funct3; mem_read && mem_write both set; halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
  - On fault: no dmem_req; fault pulses the cycle after acceptance; fault_addr = addr; state stays IDLE.
- **FSM: IDLE → REQ → (WAIT) → IDLE**
  - IDLE: a legal accepted op moves to REQ.
  - REQ: dmem_req = 1 with all dmem_* outputs stable until dmem_gnt.
    - On gnt with a store: go to IDLE and pulse store_done next cycle.
    - On gnt with a load: go to WAIT.
  - WAIT: on dmem_rvalid, latch extended data into wb_data and wb_rd; pulse wb_valid next cycle; go to IDLE.
- **Byte enables and store data** (off = addr[1:0])
  - SB: be = 4'b0001 << off; dmem_wdata = {4{wdata[7:0]}}.
  - SH: be = off[1] ? 4'b1100 : 4'b0011; dmem_wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111; dmem_wdata = wdata.
  - Loads: dmem_we = 0; dmem_be as for the matching size.
- **Load extraction**
  - Byte = dmem_rdata[8*off +: 8]; halfword = dmem_rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Loads to x0 still access memory; wb_valid pulses with wb_rd = 0.
- dmem_rvalid outside WAIT and dmem_gnt outside REQ are ignored.

## Timing
- **Reset values**
  - State IDLE; req_ready = 1.
  - dmem_req, dmem_we, wb_valid, store_done, fault = 0.
  - dmem_addr, dmem_be, dmem_wdata, wb_rd, wb_data, fault_addr = 0.
- All outputs except req_ready are registered. req_ready is decoded from state.
- **Latencies** (accept = cycle 0)
  - dmem_req rises in cycle 1.
  - Store with gnt in cycle 1: store_done in cycle 2; req_ready high in cycle 2.
  - Load with gnt in cycle 1 and rvalid in cycle 2: wb_valid in cycle 3; next accept in cycle 3.
  - Each gnt wait cycle adds one cycle. Memory returns rvalid at least one cycle after gnt.
  - Fault: pulse in cycle 1; req_ready never drops.
- **Back-to-back**
  - A new op can be accepted in the same cycle wb_valid, store_done or fault pulses.
  - Pulses never stretch beyond one cycle.
- **Reset mid-operation**
  - Asynchronous return to IDLE; dmem_req drops immediately.
  - A later stray rvalid is ignored and produces no wb_valid.

## Test plan
- LB at addr 0x103, rdata 0x80FFFFFF, gnt cycle 1, rvalid cycle 2 -> dmem_addr 0x100, be 0b1000, wb_data 0xFFFFFF80 with wb_valid in cycle 3; same access as LBU -> 0x00000080.
- SH at addr 0x22, wdata 0x1234ABCD -> dmem_we 1, be 0b1100, dmem_wdata 0xABCDABCD, addr 0x20; store_done one cycle after gnt.
- LW at 0x40 with gnt held low 3 cycles -> dmem_req and outputs stable across all REQ cycles, req_ready low throughout; wb_data = rdata.
- LW at 0x41; SH at 0x23; load funct3 011 -> fault pulse in cycle 1, fault_addr = addr, no dmem_req, req_ready stays 1.
- Load in WAIT, rst_n low mid-cycle -> dmem_req and all outputs 0 immediately; rvalid after reset release gives no wb_valid.
- SW 0x10, then LW 0x10 accepted in the store_done cycle -> second dmem_req one cycle later, no lost or duplicated pulses.
